// File: rtl/i2c_controller.sv
// Single-byte I2C master: START, {addr, R/W}, ACK, one data byte, ACK/NACK, STOP.
// Optional macro I2C_ACK_CHECK_EN: a peripheral NACK ends the transfer early through STOP.
module i2c_controller #(
  parameter int QUARTER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode,
  input  logic [6:0] periph_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] state,
  output logic       sdc,
  inout  wire        sda,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ack_err
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    ADDR      = 4'd2,
    ADDR_ACK  = 4'd3,
    WRITE     = 4'd4,
    WRITE_ACK = 4'd5,
    READ      = 4'd6,
    READ_ACK  = 4'd7,
    STOP      = 4'd8,
    DONE      = 4'd9
  } state_t;

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_ABORT = 1'b1;
`else
  localparam bit ACK_ABORT = 1'b0;
`endif

  logic [3:0]    state_reg, state_next;
  logic [1:0]    phase_reg, phase_next;
  logic [2:0]    bit_reg, bit_next;
  logic [QW-1:0] q_cnt_reg, q_next;
  logic [6:0]    addr_reg;
  logic          mode_reg;
  logic [7:0]    wdata_reg;
  logic          sdc_reg, sda_low_reg;
  logic [7:0]    rd_data_reg;
  logic          ack_err_reg;
  logic          q_tick, end_bit, sample;
  logic [7:0]    tx_byte;
  logic [1:0]    drive_next;
  logic          sda_in;

  // Bus levels for a given state/phase, returned as {scl, sda_low}.
  function automatic logic [1:0] bus_drive(input logic [3:0] st, input logic [1:0] ph,
                                           input logic tx_bit);
    bus_drive = 2'b10;
    case (st)
      START:                               bus_drive = {ph != 2'd3, ph[1]};
      ADDR, WRITE:                         bus_drive = {ph[1], ~tx_bit};
      ADDR_ACK, WRITE_ACK, READ, READ_ACK: bus_drive = {ph[1], 1'b0};
      STOP:                                bus_drive = {ph[1], ph != 2'd3};
      default:                             bus_drive = 2'b10;
    endcase
  endfunction

  assign sda_in = sda;

  always_comb begin
    q_tick     = (q_cnt_reg == Q_LAST);
    end_bit    = q_tick && (phase_reg == 2'd3);
    sample     = q_tick && (phase_reg == 2'd2);
    q_next     = q_tick ? '0 : q_cnt_reg + 1'b1;
    phase_next = q_tick ? phase_reg + 2'd1 : phase_reg;
    bit_next   = bit_reg;
    state_next = state_reg;
    if (end_bit && (state_reg == ADDR || state_reg == WRITE || state_reg == READ))
      bit_next = bit_reg + 3'd1;
    case (state_reg)
      IDLE: begin
        q_next     = '0;
        phase_next = '0;
        bit_next   = '0;
        if (enable) state_next = START;
      end
      START:     if (end_bit) state_next = ADDR;
      ADDR:      if (end_bit && bit_reg == 3'd7) state_next = ADDR_ACK;
      ADDR_ACK: begin
        if (end_bit) begin
          if (ACK_ABORT && ack_err_reg) state_next = STOP;
          else if (mode_reg)            state_next = READ;
          else                          state_next = WRITE;
        end
      end
      WRITE:     if (end_bit && bit_reg == 3'd7) state_next = WRITE_ACK;
      WRITE_ACK: if (end_bit) state_next = STOP;
      READ:      if (end_bit && bit_reg == 3'd7) state_next = READ_ACK;
      READ_ACK:  if (end_bit) state_next = STOP;
      STOP:      if (end_bit) state_next = DONE;
      default: begin
        // DONE and any illegal encoding fall back to IDLE with counters cleared
        q_next     = '0;
        phase_next = '0;
        bit_next   = '0;
        state_next = IDLE;
      end
    endcase
    tx_byte    = (state_next == WRITE) ? wdata_reg : {addr_reg, mode_reg};
    drive_next = bus_drive(state_next, phase_next, tx_byte[3'd7 - bit_next]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_reg     <= '0;
      q_cnt_reg   <= '0;
      addr_reg    <= '0;
      mode_reg    <= 1'b0;
      wdata_reg   <= '0;
      sdc_reg     <= 1'b1;
      sda_low_reg <= 1'b0;
      rd_data_reg <= '0;
      ack_err_reg <= 1'b0;
    end else begin
      state_reg                <= state_next;
      phase_reg                <= phase_next;
      bit_reg                  <= bit_next;
      q_cnt_reg                <= q_next;
      {sdc_reg, sda_low_reg}   <= drive_next;
      if (state_reg == IDLE && enable) begin
        addr_reg    <= periph_addr;
        mode_reg    <= mode;
        wdata_reg   <= wr_data;
        ack_err_reg <= 1'b0;
      end
      // Receiver side samples SDA as phase 3 begins, half way through SCL high
      if (sample) begin
        case (state_reg)
          ADDR_ACK, WRITE_ACK: if (sda_in) ack_err_reg <= 1'b1;
          READ:                rd_data_reg <= {rd_data_reg[6:0], sda_in};
          default: ;
        endcase
      end
    end
  end

  assign sda     = sda_low_reg ? 1'b0 : 1'bz;
  assign sdc     = sdc_reg;
  assign state   = state_reg;
  assign busy    = (state_reg != IDLE);
  assign rd_data = rd_data_reg;
  assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_i2c_controller.sv
// Scoreboard bench for i2c_controller: bus-level peripheral model checks every SDA slot,
// plus state sequence, timing, rd_data and ack_err against values derived here.
module tb_i2c_controller;
  localparam int Q = 1;
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] periph_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] state;
  logic       sdc;
  wire        sda_bus;
  logic [7:0] rd_data;
  logic       busy;
  logic       ack_err;

  logic       periph_low = 1'b0;
  logic       periph_present = 1'b0;
  logic [7:0] periph_tx = '0;

  pullup (sda_bus);
  assign sda_bus = periph_low ? 1'b0 : 1'bz;

  i2c_controller #(.QUARTER(Q)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .periph_addr(periph_addr), .wr_data(wr_data), .state(state),
    .sdc(sdc), .sda(sda_bus), .rd_data(rd_data), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int txn_no = 0;
  logic [7:0] rd_model = '0;
  logic bit_q[$];
  logic [3:0] st_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pop_state();
    if (st_q.size() == 0) return 4'hF;
    return st_q.pop_front();
  endfunction

  // Peripheral + bus monitor, working on levels sampled at each falling clk edge.
  initial begin
    logic prev_scl, prev_sda, scl, s, exp_bit;
    int pcnt;
    logic [7:0] p_addr;
    prev_scl = 1'b1; prev_sda = 1'b1; pcnt = 0; p_addr = '0;
    forever begin
      @(negedge clk);
      scl = sdc;
      s = sda_bus;
      if (reset) begin
        periph_low = 1'b0;
        pcnt = 0;
      end else if (prev_scl && scl && prev_sda && !s) begin
        pcnt = 0;
        start_cyc = cyc;
        periph_low = 1'b0;
      end else if (!prev_scl && scl) begin
        pcnt++;
        if (pcnt <= 8) p_addr = {p_addr[6:0], s};
        if (bit_q.size() > 0) begin
          exp_bit = bit_q.pop_front();
          check_val($sformatf("sda_slot%0d", pcnt), s, exp_bit);
        end
      end else if (prev_scl && !scl && periph_present) begin
        if (pcnt == 8) periph_low = 1'b1;
        else if (p_addr[0]) begin
          if (pcnt >= 9 && pcnt <= 16) periph_low = !periph_tx[16 - pcnt];
          else if (pcnt == 17) periph_low = 1'b0;
        end else begin
          if (pcnt == 9) periph_low = 1'b0;
          else if (pcnt == 17) periph_low = 1'b1;
          else if (pcnt == 18) periph_low = 1'b0;
        end
      end
      prev_scl = scl;
      prev_sda = s;
    end
  end

  task automatic run_txn(input logic m, input logic [6:0] a, input logic [7:0] wd,
                         input logic present, input logic [7:0] rbyte,
                         input logic hold, input logic pulse, input logic b2b);
    logic skip;
    logic [7:0] ab, db;
    logic [3:0] last;
    int t0, t1, steps;
    skip = ACK_CHECK && !present;
    ab = {a, m};
    for (int i = 7; i >= 0; i--) bit_q.push_back(ab[i]);
    bit_q.push_back(!present);
    st_q.push_back(4'd1); st_q.push_back(4'd2); st_q.push_back(4'd3);
    if (!skip) begin
      db = m ? (present ? rbyte : 8'hFF) : wd;
      for (int i = 7; i >= 0; i--) bit_q.push_back(db[i]);
      bit_q.push_back(m ? 1'b1 : !present);
      if (m) begin st_q.push_back(4'd6); st_q.push_back(4'd7); rd_model = db; end
      else   begin st_q.push_back(4'd4); st_q.push_back(4'd5); end
    end
    st_q.push_back(4'd8); st_q.push_back(4'd9); st_q.push_back(4'd0);

    periph_present = present;
    periph_tx = rbyte;
    mode = m; periph_addr = a; wr_data = wd; enable = 1'b1;
    steps = 0;
    @(negedge clk);
    while (state == 4'd0 && steps < 10) begin @(negedge clk); steps++; end
    t0 = cyc;
    check_val("state_start", state, pop_state());
    if (b2b) check_val("idle_gap", t0 - done_cyc, 2);
    // Inputs after START must be ignored
    mode = ~m; periph_addr = ~a; wr_data = ~wd;
    if (pulse) enable = 1'b0;
    last = state;
    steps = 0;
    while (state != 4'd9 && steps < 300) begin
      @(negedge clk);
      steps++;
      if (cyc == t0 + 30) enable = 1'b1;
      if (state != last) begin
        check_val("state_seq", state, pop_state());
        last = state;
      end
    end
    t1 = cyc;
    done_cyc = t1;
    check_val("done_reached", state, 4'd9);
    check_val("txn_cycles", t1 - t0, skip ? 44 * Q : 80 * Q);
    check_val("start_edge", start_cyc - t0, 2);
    check_val("rd_data", rd_data, rd_model);
    check_val("ack_err", ack_err, !present);
    check_val("busy_done", busy, 1'b1);
    enable = hold;
    @(negedge clk);
    check_val("state_end", state, pop_state());
    check_val("busy_idle", busy, 1'b0);
    check_val("slots_left", bit_q.size(), 0);
    bit_q.delete();
    st_q.delete();
    txn_no++;
    $display("txn %0d: mode=%0d addr=%02h wd=%02h periph=%0d rd=%02h ack_err=%0d cycles=%0d",
             txn_no, m, a, wd, present, rd_data, ack_err, t1 - t0);
  endtask

  initial begin
    int steps;
    repeat (3) @(negedge clk);
    check_val("rst_state", state, 4'd0);
    check_val("rst_sdc", sdc, 1'b1);
    check_val("rst_sda", sda_bus, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_rd_data", rd_data, 8'h00);
    check_val("rst_ack_err", ack_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 7'h03, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_txn(1'b0, 7'h50, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run_txn(1'b0, 7'h2A, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    run_txn(1'b0, 7'h50, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_txn(1'b1, 7'h7F, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Abort with reset while the address byte is on the bus
    periph_present = 1'b1;
    mode = 1'b0; periph_addr = 7'h11; wr_data = 8'h22; enable = 1'b1;
    steps = 0;
    while (state != 4'd2 && steps < 20) begin @(negedge clk); steps++; end
    enable = 1'b0;
    check_val("reach_addr", state, 4'd2);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("abort_state", state, 4'd0);
    check_val("abort_sdc", sdc, 1'b1);
    check_val("abort_sda", sda_bus, 1'b1);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_rd_data", rd_data, 8'h00);
    rd_model = '0;
    $display("txn %0d: reset asserted during ADDR, state=%0d sdc=%0d", txn_no + 1, state, sdc);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    force dut.state_reg = 4'hC;
    #1 check_val("forced_state", state, 4'hC);
    release dut.state_reg;
    @(negedge clk);
    check_val("illegal_recover", state, 4'd0);
    check_val("illegal_sdc", sdc, 1'b1);
    $display("txn %0d: illegal state 0xC recovered to %0d", txn_no + 2, state);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
